intercal_deposit: RTL



---
 rtl/intercal_deposit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/intercal_deposit.sv
// intercal_deposit: multi-cycle inverse unit for the INTERCAL ALU.
// DEPOSIT32/DEPOSIT16 scatter low-order source bits into the positions
// marked by the mask (inverse of select); UNMINGLE splits an interleaved
// word into {odd bits, even bits} (inverse of mingle). One result bit
// position is processed per cycle over a fixed 32-cycle scan.
module intercal_deposit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_DEP32 = 2'd0;
  localparam logic [1:0] OP_DEP16 = 2'd1;
  localparam logic [1:0] OP_UNMNG = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] r_q, r_d;
  logic [4:0]  j_q, j_d;
  // k counts consumed source bits in 32-bit mode (0..32, so 6 bits);
  // kl/kh do the same per half in 16-bit mode (0..16, so 5 bits).
  logic [5:0]  k_q, k_d;
  logic [4:0]  kl_q, kl_d;
  logic [4:0]  kh_q, kh_d;

  // Source indices: low/high half pointers for DEPOSIT16, and the
  // destination of bit j for UNMINGLE (odd bits go to the upper half).
  logic [4:0]  lo_idx_s;
  logic [4:0]  hi_idx_s;
  logic [4:0]  unm_idx_s;

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      r_q     <= 32'd0;
      j_q     <= 5'd0;
      k_q     <= 6'd0;
      kl_q    <= 5'd0;
      kh_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      j_q     <= j_d;
      k_q     <= k_d;
      kl_q    <= kl_d;
      kh_q    <= kh_d;
    end
  end

  // Next-state logic: accept in IDLE, scan one position per RUN cycle,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    j_d       = j_q;
    k_d       = k_q;
    kl_d      = kl_q;
    kh_d      = kh_q;
    lo_idx_s  = {1'b0, kl_q[3:0]};
    hi_idx_s  = {1'b1, kh_q[3:0]};
    unm_idx_s = {j_q[0], j_q[4:1]};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          r_d     = 32'd0;
          j_d     = 5'd0;
          k_d     = 6'd0;
          kl_d    = 5'd0;
          kh_d    = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        j_d = j_q + 5'd1;
        if (j_q == 5'd31) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end

        case (op_q)
          OP_DEP32: begin
            if (b_q[j_q]) begin
              r_d[j_q] = a_q[k_q[4:0]];
              k_d      = k_q + 6'd1;
            end else begin
              r_d[j_q] = 1'b0;
            end
          end
          OP_DEP16: begin
            // Halves are independent: low mask bits draw from a[15:0],
            // high mask bits draw from a[31:16].
            if (j_q[4] == 1'b0) begin
              if (b_q[j_q]) begin
                r_d[j_q] = a_q[lo_idx_s];
                kl_d     = kl_q + 5'd1;
              end else begin
                r_d[j_q] = 1'b0;
              end
            end else begin
              if (b_q[j_q]) begin
                r_d[j_q] = a_q[hi_idx_s];
                kh_d     = kh_q + 5'd1;
              end else begin
                r_d[j_q] = 1'b0;
              end
            end
          end
          OP_UNMNG: begin
            r_d[unm_idx_s] = a_q[j_q];
          end
          default: begin
            // Reserved op: result stays zero, timing unchanged.
            r_d = r_q;
          end
        endcase
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign f         = (state_q == S_DONE) ? r_q : 32'd0;

endmodule
